scan_unload_ctrl: RTL and testbench

SCAN_UNLOAD_CTRL -- requirements
Module: scan_unload_ctrl

---
 rtl/scan_unload_ctrl_pkg.sv | 13 +
 rtl/scan_unload_ctrl_if.sv | 29 ++
 rtl/scan_unload_ctrl_scan_cell.sv | 25 ++
 rtl/scan_unload_ctrl.sv | 106 ++++++++++
 tb/tb_scan_unload_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/scan_unload_ctrl_pkg.sv
// Shared types and constants for the scan unload controller.
// Holds the FSM state encoding and the default chain length.
package scan_unload_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_FIN   = 2'b10
    } state_t;

endpackage

// File: rtl/scan_unload_ctrl_if.sv
// Control/data bundle between a scan unload requester and the controller.
// The master drives capture and scan-in; the slave returns scan-out and status.
interface scan_unload_ctrl_if
    import scan_unload_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             EN;
    logic             CAP;
    logic [WIDTH-1:0] D;
    logic             SI;
    logic             SO;
    logic             SO_VLD;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] Q;

    modport master (
        output EN, CAP, D, SI,
        input  SO, SO_VLD, BUSY, DONE, Q
    );

    modport slave (
        input  EN, CAP, D, SI,
        output SO, SO_VLD, BUSY, DONE, Q
    );

endinterface

// File: rtl/scan_unload_ctrl_scan_cell.sv
// One scan chain bit: parallel load when i_sln=0, serial shift when i_sln=1.
// Holds its value whenever i_en is low; contains no sequencing logic.
module scan_cell (
    input  logic CLK,
    input  logic ALn,
    input  logic i_en,
    input  logic i_sln,
    input  logic i_d,
    input  logic i_sd,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= i_sln ? i_sd : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/scan_unload_ctrl.sv
// Scan unload controller: captures D into a WIDTH-bit chain, then shifts it out
// LSB first on SO while SI fills from the MSB, ending with a one-cycle DONE.
module scan_unload_ctrl
    import scan_unload_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              CLK,
    input  logic              ALn,
    scan_unload_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_chain;
    logic [WIDTH-1:0] w_sd;
    logic             w_last;
    logic             w_cell_en;
    logic             w_sln;
    logic             w_so_vld;
    logic             w_busy;
    logic             w_done;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            r_state <= ST_IDLE;
        end else if (bus.EN) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.CAP) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)  w_next = ST_FIN;
            ST_FIN:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Counter wraps to zero on the final shift so it never passes WIDTH-1.
    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            r_cnt <= '0;
        end else if (bus.EN) begin
            if (r_state == ST_IDLE && bus.CAP) begin
                r_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_cell_en = 1'b0;
        w_sln     = 1'b0;
        w_so_vld  = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cell_en = bus.EN && bus.CAP;
            end
            ST_SHIFT: begin
                w_cell_en = bus.EN;
                w_sln     = 1'b1;
                w_so_vld  = bus.EN;
                w_busy    = 1'b1;
            end
            ST_FIN: begin
                w_busy    = 1'b1;
                w_done    = 1'b1;
            end
            default: begin
                w_cell_en = 1'b0;
            end
        endcase
    end

    assign w_sd = {bus.SI, w_chain[WIDTH-1:1]};

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        scan_cell u_cell (
            .CLK   (CLK),
            .ALn   (ALn),
            .i_en  (w_cell_en),
            .i_sln (w_sln),
            .i_d   (bus.D[gi]),
            .i_sd  (w_sd[gi]),
            .o_q   (w_chain[gi])
        );
    end

    assign bus.SO     = w_chain[0];
    assign bus.Q      = w_chain;
    assign bus.SO_VLD = w_so_vld;
    assign bus.BUSY   = w_busy;
    assign bus.DONE   = w_done;

endmodule

// File: tb/tb_scan_unload_ctrl.sv
// Scoreboard bench for scan_unload_ctrl: directed scenarios plus random traffic,
// checked against a bit-queue model of the unload behaviour.
module tb_scan_unload_ctrl;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic ALn;

    scan_unload_ctrl_if #(.WIDTH(W)) bus ();

    scan_unload_ctrl #(.WIDTH(W)) dut (
        .CLK (CLK),
        .ALn (ALn),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int           nChecks = 0;
    int           nFail   = 0;
    bit           soQ[$];
    logic [W-1:0] doneQ[$];
    logic [W-1:0] mChain;
    int           mRem;
    bit           mFin;
    bit           monOn;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted capture queues all W data bits; W enabled cycles drain them, then one DONE.
    task automatic modelStep();
        if (mRem == 0 && !mFin) begin
            if (bus.EN && bus.CAP) begin
                mChain = bus.D;
                mRem   = W;
                for (int i = 0; i < W; i++) soQ.push_back(bus.D[i]);
            end
        end else if (mRem > 0) begin
            if (bus.EN) begin
                mChain = {bus.SI, mChain[W-1:1]};
                mRem--;
                if (mRem == 0) begin
                    mFin = 1'b1;
                    doneQ.push_back(mChain);
                end
            end
        end else if (bus.EN) begin
            mFin = 1'b0;
        end
    endtask

    task automatic modelReset();
        soQ.delete();
        doneQ.delete();
        mChain = '0;
        mRem   = 0;
        mFin   = 1'b0;
    endtask

    task automatic applyStimulus(input bit en, input bit cap, input logic [W-1:0] d, input bit si);
        bus.EN  = en;
        bus.CAP = cap;
        bus.D   = d;
        bus.SI  = si;
        @(posedge CLK);
        modelStep();
        #2;
    endtask

    task automatic unload(input logic [W-1:0] d, input logic [W-1:0] siBits,
                          input int gapAfter, input int gapLen, input bit capBusy);
        logic [W-1:0] busyD;
        busyD = capBusy ? '1 : d;
        applyStimulus(1'b1, 1'b1, d, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (i == gapAfter) begin
                for (int g = 0; g < gapLen; g++) applyStimulus(1'b0, capBusy, busyD, siBits[i]);
            end
            applyStimulus(1'b1, capBusy, busyD, siBits[i]);
        end
        applyStimulus(1'b1, capBusy, busyD, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_q"},      32'(bus.Q),      32'(0));
        checkOutput({tag, "_so"},     32'(bus.SO),     32'(0));
        checkOutput({tag, "_so_vld"}, 32'(bus.SO_VLD), 32'(0));
        checkOutput({tag, "_busy"},   32'(bus.BUSY),   32'(0));
        checkOutput({tag, "_done"},   32'(bus.DONE),   32'(0));
    endtask

    always @(negedge CLK) begin
        if (monOn && ALn) begin
            checkOutput("so_vld", 32'(bus.SO_VLD), 32'(bus.EN && (mRem > 0)));
            checkOutput("busy",   32'(bus.BUSY),   32'((mRem > 0) || mFin));
            checkOutput("done",   32'(bus.DONE),   32'(mFin));
            checkOutput("q",      32'(bus.Q),      32'(mChain));
            if (bus.SO_VLD === 1'b1) begin
                if (soQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("[TB] FAIL so_unexpected: got SO_VLD=1, expected no pending bit at %0t", $time);
                end else begin
                    checkOutput("so_bit", 32'(bus.SO), 32'(soQ.pop_front()));
                end
            end
            if (bus.DONE === 1'b1 && bus.EN === 1'b1) begin
                if (doneQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("[TB] FAIL done_unexpected: got DONE=1, expected no pending unload at %0t", $time);
                end else begin
                    checkOutput("done_q", 32'(bus.Q), 32'(doneQ.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.EN  = 1'b0;
        bus.CAP = 1'b0;
        bus.D   = '0;
        bus.SI  = 1'b0;
        ALn     = 1'b1;
        monOn   = 1'b0;
        modelReset();

        #1 ALn = 1'b0;
        #1 checkResetState("reset");
        @(posedge CLK);
        #2 ALn = 1'b1;
        monOn = 1'b1;
        $display("[TB] reset released at %0t", $time);

        unload(8'hA5, 8'h00, -1, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("q_after_a5", 32'(bus.Q), 32'(8'h00));

        unload(8'h3C, 8'h53, -1, 0, 1'b0);
        checkOutput("q_after_3c", 32'(bus.Q), 32'(8'h53));

        unload(8'h96, 8'hC5, 4, 3, 1'b0);
        unload(8'h6B, 8'h2E, -1, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);

        // Abort an unload after five shifted bits.
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);
        ALn = 1'b0;
        modelReset();
        #1 checkResetState("abort");
        @(posedge CLK);
        #2 checkResetState("abort_hold");
        ALn = 1'b1;
        unload(8'h81, 8'h00, -1, 0, 1'b0);

        unload(8'hC3, 8'h5A, -1, 0, 1'b0);
        unload(8'h3A, 8'hE1, -1, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);

        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                          W'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 40 && (mRem > 0 || mFin); n++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        @(negedge CLK);
        #1;
        checkOutput("so_queue_drained",   32'(soQ.size()),   32'(0));
        checkOutput("done_queue_drained", 32'(doneQ.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
